ctrl_conv_input: RTL and testbench

- Input-side controller for the convolution datapath. It is the receiving end of the AXI-style valid/ready streams that feed the X and F memories.
- It accepts exactly X_MEM_SIZE x-samples and F_MEM_SIZE f-coefficients, generating write enables and addresses for both memories.
- Once both memories are full, it raises conv_start and holds it until the output controller returns conv_done. It then re-opens both input streams for the next vector.

---
 rtl/ctrl_conv_input.sv | 110 +++++++++++
 tb/tb_ctrl_conv_input.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_conv_input.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_conv_input
//  Purpose  : Input-side controller for the convolution datapath. Terminates
//             the X-sample and F-coefficient valid/ready streams, generates
//             write strobes/addresses for the X and F memories, and raises
//             conv_start (level) once both memories are full, holding it
//             until the output controller pulses conv_done.
//  Ports    : clk, reset         - clock, synchronous active-high reset
//             s_valid_x/s_ready_x - X sample stream handshake
//             s_valid_f/s_ready_f - F coefficient stream handshake
//             x_wr_en/x_wr_addr   - X memory write port (zero latency)
//             f_wr_en/f_wr_addr   - F memory write port (zero latency)
//             conv_start          - both memories loaded, convolution running
//             conv_done           - one-cycle pulse, convolution finished
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_conv_input #(
  parameter int unsigned F_MEM_SIZE       = 4,
  parameter int unsigned X_MEM_SIZE       = 8,
  parameter int unsigned X_MEM_ADDR_WIDTH = 3,
  parameter int unsigned F_MEM_ADDR_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  output logic                        x_wr_en,
  output logic [X_MEM_ADDR_WIDTH-1:0] x_wr_addr,
  output logic                        f_wr_en,
  output logic [F_MEM_ADDR_WIDTH-1:0] f_wr_addr,
  output logic                        conv_start,
  input  logic                        conv_done
);

  localparam logic [X_MEM_ADDR_WIDTH-1:0] c_X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
  localparam logic [F_MEM_ADDR_WIDTH-1:0] c_F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [X_MEM_ADDR_WIDTH-1:0] r_x_cnt;
  logic [F_MEM_ADDR_WIDTH-1:0] r_f_cnt;
  logic                        r_x_full;
  logic                        r_f_full;
  logic                        r_conv_start;

  logic                        w_x_full_nxt;
  logic                        w_f_full_nxt;

  // Ready depends only on state and the full flags, never on valid.
  assign s_ready_x  = (r_state == ST_LOAD) && !r_x_full;
  assign s_ready_f  = (r_state == ST_LOAD) && !r_f_full;
  assign x_wr_en    = s_valid_x && s_ready_x;
  assign f_wr_en    = s_valid_f && s_ready_f;
  assign x_wr_addr  = r_x_cnt;
  assign f_wr_addr  = r_f_cnt;
  assign conv_start = r_conv_start;

  // Full flags as they will be after this edge. Using these (rather than the
  // registered flags) for the LOAD->CONV decision gives conv_start exactly one
  // cycle of latency after the final handshake. The flags are needed at all
  // because the counters wrap to 0 when the memory size is a power of two.
  assign w_x_full_nxt = r_x_full || (x_wr_en && (r_x_cnt == c_X_LAST));
  assign w_f_full_nxt = r_f_full || (f_wr_en && (r_f_cnt == c_F_LAST));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_x_full_nxt && w_f_full_nxt) w_state_nxt = ST_CONV;
      ST_CONV: if (conv_done)                    w_state_nxt = ST_LOAD;
      default:                                   w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_LOAD;
      r_x_cnt      <= '0;
      r_f_cnt      <= '0;
      r_x_full     <= 1'b0;
      r_f_full     <= 1'b0;
      r_conv_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_LOAD) begin
        if (x_wr_en) r_x_cnt <= (r_x_cnt == c_X_LAST) ? '0 : r_x_cnt + 1'b1;
        if (f_wr_en) r_f_cnt <= (r_f_cnt == c_F_LAST) ? '0 : r_f_cnt + 1'b1;
        r_x_full     <= w_x_full_nxt;
        r_f_full     <= w_f_full_nxt;
        r_conv_start <= w_x_full_nxt && w_f_full_nxt;
      end else if (conv_done) begin
        // Convolution finished: reopen both streams from address 0.
        r_x_cnt      <= '0;
        r_f_cnt      <= '0;
        r_x_full     <= 1'b0;
        r_f_full     <= 1'b0;
        r_conv_start <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_conv_input.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_conv_input
//  Purpose  : Directed self-checking bench for ctrl_conv_input. Inputs change
//             1 time unit after posedge; outputs are sampled at negedge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_conv_input;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid_x, s_ready_x, s_valid_f, s_ready_f;
  logic       x_wr_en, f_wr_en, conv_start, conv_done;
  logic [2:0] x_wr_addr;
  logic [1:0] f_wr_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_conv_input #(
    .F_MEM_SIZE(4), .X_MEM_SIZE(8), .X_MEM_ADDR_WIDTH(3), .F_MEM_ADDR_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr),
    .f_wr_en(f_wr_en), .f_wr_addr(f_wr_addr),
    .conv_start(conv_start), .conv_done(conv_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the sampling point of the current cycle.
  task automatic sample();
    @(negedge clk);
  endtask

  // Finish the current cycle; inputs for the next cycle may then be driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; s_valid_x = 1'b0; s_valid_f = 1'b0; conv_done = 1'b0;
    next_cycle();
    next_cycle();

    // ---- Reset state ----
    sample();
    chk("rst_ready_x", s_ready_x, 1);
    chk("rst_ready_f", s_ready_f, 1);
    chk("rst_x_wr_en", x_wr_en, 0);
    chk("rst_f_wr_en", f_wr_en, 0);
    chk("rst_x_addr", x_wr_addr, 0);
    chk("rst_f_addr", f_wr_addr, 0);
    chk("rst_conv_start", conv_start, 0);
    next_cycle();
    reset = 1'b0;

    // ---- Contiguous load: x 8 cycles, f 4 cycles ----
    for (int i = 0; i < 8; i++) begin
      s_valid_x = 1'b1;
      s_valid_f = (i < 4);
      sample();
      chk("c_x_wr_en", x_wr_en, 1);
      chk("c_x_addr", x_wr_addr, i);
      chk("c_ready_f", s_ready_f, (i < 4));
      chk("c_f_wr_en", f_wr_en, (i < 4));
      if (i < 4) chk("c_f_addr", f_wr_addr, i);
      chk("c_conv_start", conv_start, 0);
      next_cycle();
    end

    // ---- Valids held in CONV: no writes, readies low ----
    s_valid_x = 1'b1; s_valid_f = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      chk("cv_conv_start", conv_start, 1);
      chk("cv_ready_x", s_ready_x, 0);
      chk("cv_ready_f", s_ready_f, 0);
      chk("cv_x_wr_en", x_wr_en, 0);
      chk("cv_f_wr_en", f_wr_en, 0);
      next_cycle();
    end

    // ---- conv_done during CONV ----
    s_valid_x = 1'b0; s_valid_f = 1'b0; conv_done = 1'b1;
    sample();
    chk("cd_start_during", conv_start, 1);
    next_cycle();
    conv_done = 1'b0;
    sample();
    chk("cd_start_after", conv_start, 0);
    chk("cd_ready_x", s_ready_x, 1);
    chk("cd_ready_f", s_ready_f, 1);
    chk("cd_x_addr", x_wr_addr, 0);
    chk("cd_f_addr", f_wr_addr, 0);
    next_cycle();

    // ---- Throttled x valid, conv_done ignored in LOAD (cycle 5) ----
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      s_valid_x = ((i % 2) == 0);
      s_valid_f = (i < 4);
      conv_done = (i == 5);
      sample();
      chk("t_x_wr_en", x_wr_en, ((i % 2) == 0));
      if (x_wr_en) begin
        chk("t_x_addr", x_wr_addr, pulses);
        pulses++;
      end
      chk("t_conv_start", conv_start, 0);
      next_cycle();
    end
    s_valid_x = 1'b0; s_valid_f = 1'b0; conv_done = 1'b0;
    chk("t_pulses", pulses, 8);
    sample();
    chk("t_conv_start_rise", conv_start, 1);
    next_cycle();
    conv_done = 1'b1;
    next_cycle();
    conv_done = 1'b0;

    // ---- F finishes last: x at cycles 0..7, f at 10,12,14,20 ----
    for (int i = 0; i < 22; i++) begin
      s_valid_x = (i < 8);
      s_valid_f = (i == 10 || i == 12 || i == 14 || i == 20);
      sample();
      chk("fl_ready_x", s_ready_x, (i < 8));
      chk("fl_f_wr_en", f_wr_en, (i == 10 || i == 12 || i == 14 || i == 20));
      chk("fl_conv_start", conv_start, (i >= 21));
      next_cycle();
    end
    s_valid_x = 1'b0; s_valid_f = 1'b0;
    conv_done = 1'b1;
    next_cycle();
    conv_done = 1'b0;

    // ---- Reset after 5 x-writes and 2 f-writes ----
    for (int i = 0; i < 5; i++) begin
      s_valid_x = 1'b1;
      s_valid_f = (i < 2);
      next_cycle();
    end
    reset = 1'b1;   // handshakes still offered: reset must win
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_valid_x = (i < 8);
      s_valid_f = (i < 4);
      sample();
      if (i < 8) chk("r_x_addr", x_wr_addr, i);
      if (i < 4) chk("r_f_addr", f_wr_addr, i);
      chk("r_conv_start", conv_start, (i == 8));
      next_cycle();
    end
    s_valid_x = 1'b0; s_valid_f = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
